// File: rtl/audio_tdm_clk_v.sv
// Audio MCLK/BCLK/frame-sync generator for I2S and TDM codecs, with slot, sample and block strobes and a timed codec reset.
// Optional AUDIO_TDM_CLK_RATE_SEL_EN adds rate_sel_i, which is applied at frame boundaries.
`timescale 1ns/1ps
module audio_tdm_clk_v #(
  parameter int MCLK_DIV_BITS = 4,
  parameter int SLOTS         = 2,
  parameter int SLOT_BITS     = 32,
  parameter int FRAME_SAMPLES = 128,
  parameter int RST_SAMPLES   = 4,
  parameter int FSYNC_MODE    = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
`ifdef AUDIO_TDM_CLK_RATE_SEL_EN
  input  logic [1:0] rate_sel_i,
`endif
  output logic mclk_o,
  output logic bclk_o,
  output logic fsync_o,
  output logic [((SLOTS > 1) ? $clog2(SLOTS) : 1)-1:0] slot_o,
  output logic slotstart_o,
  output logic sampstart_o,
  output logic framestart_o,
  output logic codec_rst_no
);

  localparam int PRE_W      = MCLK_DIV_BITS + 1;
  localparam int BIT_W      = $clog2(SLOT_BITS);
  localparam int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int SAMP_W     = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
  localparam int RST_W      = 8;
  localparam int FRAME_BITS = SLOTS * SLOT_BITS;
  localparam int FPOS_W     = $clog2(FRAME_BITS + 1);

  if (FSYNC_MODE == 0 && (FRAME_BITS % 2) != 0) begin : g_odd_frame
    $error("FSYNC_MODE 0 needs an even number of BCLKs per frame");
  end
  if (MCLK_DIV_BITS < 3 || MCLK_DIV_BITS > 8) begin : g_bad_div
    $error("MCLK_DIV_BITS must be in 3..8");
  end

  logic [PRE_W-1:0]  pre_reg, pre_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [SLOT_W-1:0] slot_reg, slot_next;
  logic [SAMP_W-1:0] samp_reg, samp_next;
  logic [RST_W-1:0]  rst_cnt_reg, rst_cnt_next;
  logic              codec_reg, codec_next;
  logic              fsync_reg, fsync_next;
  logic              slot_stb_reg, samp_stb_reg, frame_stb_reg;
  logic              slot_stb, samp_stb, frame_stb;
  logic              tick;
  logic [PRE_W-1:0]  tick_mask, pre_mclk, pre_bclk;
  logic [FPOS_W-1:0] fpos_next;
  int                k_eff;

`ifdef AUDIO_TDM_CLK_RATE_SEL_EN
  logic [1:0] rate_reg, rate_next;

  always_comb begin
    k_eff = MCLK_DIV_BITS - int'(rate_reg);
    if (k_eff < 2) k_eff = 2;
  end
`else
  assign k_eff = MCLK_DIV_BITS;
`endif

  // Bits above the effective divider keep counting but never reach the outputs.
  assign tick_mask = PRE_W'((32'd1 << (k_eff + 1)) - 32'd1);
  assign pre_mclk  = pre_reg >> (k_eff - 2);
  assign pre_bclk  = pre_reg >> k_eff;
  assign tick      = en_i && ((pre_reg & tick_mask) == tick_mask);

  always_comb begin
    pre_next     = pre_reg + 1'b1;
    bit_next     = bit_reg;
    slot_next    = slot_reg;
    samp_next    = samp_reg;
    rst_cnt_next = rst_cnt_reg;
    codec_next   = codec_reg;
    slot_stb     = 1'b0;
    samp_stb     = 1'b0;
    frame_stb    = 1'b0;
    if (tick) begin
      if (bit_reg == BIT_W'(SLOT_BITS - 1)) begin
        bit_next = '0;
        slot_stb = 1'b1;
        if (slot_reg == SLOT_W'(SLOTS - 1)) begin
          slot_next = '0;
          samp_stb  = 1'b1;
        end else begin
          slot_next = slot_reg + 1'b1;
        end
      end else begin
        bit_next = bit_reg + 1'b1;
      end
    end
    if (samp_stb) begin
      if (samp_reg == SAMP_W'(FRAME_SAMPLES - 1)) begin
        samp_next = '0;
        frame_stb = 1'b1;
      end else begin
        samp_next = samp_reg + 1'b1;
      end
      // Codec reset releases together with the RST_SAMPLES-th sample strobe.
      if (!codec_reg) begin
        if (rst_cnt_reg == RST_W'(RST_SAMPLES - 1)) codec_next = 1'b1;
        else rst_cnt_next = rst_cnt_reg + 1'b1;
      end
    end
    if (!en_i) begin
      pre_next  = '0;
      bit_next  = '0;
      slot_next = '0;
      samp_next = '0;
    end
  end

  assign fpos_next = FPOS_W'(slot_next) * FPOS_W'(SLOT_BITS) + FPOS_W'(bit_next);

  always_comb begin
    if (FSYNC_MODE == 0) fsync_next = en_i && (fpos_next >= FPOS_W'(FRAME_BITS / 2));
    else                 fsync_next = en_i && (fpos_next == FPOS_W'(FRAME_BITS - 1));
  end

`ifdef AUDIO_TDM_CLK_RATE_SEL_EN
  always_comb begin
    rate_next = rate_reg;
    if (samp_stb) rate_next = rate_sel_i;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pre_reg       <= '0;
      bit_reg       <= '0;
      slot_reg      <= '0;
      samp_reg      <= '0;
      rst_cnt_reg   <= '0;
      codec_reg     <= 1'b0;
      fsync_reg     <= 1'b0;
      slot_stb_reg  <= 1'b0;
      samp_stb_reg  <= 1'b0;
      frame_stb_reg <= 1'b0;
`ifdef AUDIO_TDM_CLK_RATE_SEL_EN
      rate_reg      <= 2'b00;
`endif
    end else begin
      pre_reg       <= pre_next;
      bit_reg       <= bit_next;
      slot_reg      <= slot_next;
      samp_reg      <= samp_next;
      rst_cnt_reg   <= rst_cnt_next;
      codec_reg     <= codec_next;
      fsync_reg     <= fsync_next;
      slot_stb_reg  <= slot_stb;
      samp_stb_reg  <= samp_stb;
      frame_stb_reg <= frame_stb;
`ifdef AUDIO_TDM_CLK_RATE_SEL_EN
      rate_reg      <= rate_next;
`endif
    end
  end

  assign mclk_o       = pre_mclk[0];
  assign bclk_o       = pre_bclk[0];
  assign fsync_o      = fsync_reg;
  assign slot_o       = slot_reg;
  assign slotstart_o  = slot_stb_reg;
  assign sampstart_o  = samp_stb_reg;
  assign framestart_o = frame_stb_reg;
  assign codec_rst_no = codec_reg;

endmodule
